// File: rtl/text_pkg.sv
// Shared definitions for the text banner controller: FSM encodings, text-area
// geometry and the space character code.
package text_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLINK = 2'd2
  } state_t;

  localparam int          TEXT_AREA_W = 256;
  localparam int          CHAR_PX     = 16;
  localparam logic [6:0]  SPACE_CODE  = 7'h20;

  // Only levels 1..9 are displayable; anything else is treated as noise.
  function automatic logic level_valid(input logic [3:0] lv);
    return (lv >= 4'd1) && (lv <= 4'd9);
  endfunction

endpackage

// File: rtl/text_banner_ctl_if.sv
// Pixel/ROM bus of the text banner controller. The video side (master) drives
// coordinates, vblnk, level and the ROM reply; the controller (slave) answers.
interface text_banner_ctl_if;
  logic [3:0]  level;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        vblnk;
  logic [6:0]  char_code;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [3:0]  level_lat;
  logic        banner_on;
  logic [6:0]  code_out;

  modport master (
    output level, hcount, vcount, vblnk, char_code,
    input  char_xy, char_line, level_lat, banner_on, code_out
  );

  modport slave (
    input  level, hcount, vcount, vblnk, char_code,
    output char_xy, char_line, level_lat, banner_on, code_out
  );
endinterface

// File: rtl/text_addr_gen.sv
// Text-area compare and character-cell address generation, one register stage
// after hcount/vcount.
module text_addr_gen
  import text_pkg::*;
#(
  parameter logic [10:0] XPOS = 11'd384,
  parameter logic [10:0] YPOS = 11'd172
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  output logic        in_area_o,
  output logic [7:0]  char_xy_o,
  output logic [3:0]  char_line_o
);

  logic [10:0] dx, dy;
  logic        in_x, in_y;
  logic        in_area_d, in_area_q;
  logic [7:0]  char_xy_d, char_xy_q;
  logic [3:0]  char_line_d, char_line_q;

  // Offsets wrap when left of/above the area, so the >= guard is required.
  assign dx   = hcount_i - XPOS;
  assign dy   = vcount_i - YPOS;
  assign in_x = (hcount_i >= XPOS) && (dx < 11'(TEXT_AREA_W));
  assign in_y = (vcount_i >= YPOS) && (dy < 11'(TEXT_AREA_W));

  assign in_area_d   = in_x && in_y;
  assign char_xy_d   = {dy[7:4], dx[7:4]};
  assign char_line_d = dy[3:0];

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      in_area_q   <= 1'b0;
      char_xy_q   <= 8'd0;
      char_line_q <= 4'd0;
    end else begin
      in_area_q   <= in_area_d;
      char_xy_q   <= char_xy_d;
      char_line_q <= char_line_d;
    end
  end

  assign in_area_o   = in_area_q;
  assign char_xy_o   = char_xy_q;
  assign char_line_o = char_line_q;

endmodule

// File: rtl/text_banner_ctl.sv
// Level banner controller: shows "level N" text for SHOW_FRAMES frames, then
// optionally blinks for BLINK_FRAMES frames (macro TEXT_BANNER_BLINK_EN).
module text_banner_ctl
  import text_pkg::*;
#(
  parameter logic [10:0] XPOS         = 11'd384,
  parameter logic [10:0] YPOS         = 11'd172,
  parameter logic [7:0]  SHOW_FRAMES  = 8'd120,
  parameter logic [7:0]  BLINK_FRAMES = 8'd64
) (
  input  logic              pclk,
  input  logic              rst,
  text_banner_ctl_if.slave  bus,
  output state_t            state_o,
  output logic [7:0]        frm_cnt_o,
  output logic              pending_o
);

  state_t      state_d, state_q;
  logic [7:0]  frm_d, frm_q;
  logic        pend_d, pend_q;
  logic [3:0]  lat_d, lat_q;
  logic        vblnk_q;
  logic [6:0]  code_q;
  logic        banner_q;
  logic        tick, level_chg, pend_eff, vis;
  logic        in_area;

  text_addr_gen #(.XPOS(XPOS), .YPOS(YPOS)) u_addr (
    .pclk        (pclk),
    .rst         (rst),
    .hcount_i    (bus.hcount),
    .vcount_i    (bus.vcount),
    .in_area_o   (in_area),
    .char_xy_o   (bus.char_xy),
    .char_line_o (bus.char_line)
  );

  assign tick      = bus.vblnk && !vblnk_q;
  assign level_chg = (bus.level != lat_q) && level_valid(bus.level);
  // A change seen in the tick cycle itself is honoured at that tick.
  assign pend_eff  = pend_q || level_chg;

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    pend_d  = pend_eff;
    lat_d   = lat_q;
    if (tick) begin
      if (pend_eff) begin
        state_d = SHOW;
        frm_d   = 8'd0;
        pend_d  = 1'b0;
        if (level_valid(bus.level)) lat_d = bus.level;
      end else begin
        case (state_q)
          SHOW: begin
            if (frm_q == SHOW_FRAMES - 8'd1) begin
`ifdef TEXT_BANNER_BLINK_EN
              state_d = BLINK;
`else
              state_d = IDLE;
`endif
              frm_d = 8'd0;
            end else begin
              frm_d = frm_q + 8'd1;
            end
          end
`ifdef TEXT_BANNER_BLINK_EN
          BLINK: begin
            if (frm_q == BLINK_FRAMES - 8'd1) begin
              state_d = IDLE;
              frm_d   = 8'd0;
            end else begin
              frm_d = frm_q + 8'd1;
            end
          end
`endif
          default: begin
            state_d = IDLE;
            frm_d   = 8'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    vis = 1'b0;
    case (state_q)
      SHOW:    vis = 1'b1;
`ifdef TEXT_BANNER_BLINK_EN
      BLINK:   vis = ~frm_q[3];
`endif
      default: vis = 1'b0;
    endcase
  end

`ifndef TEXT_BANNER_BLINK_EN
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      frm_q    <= 8'd0;
      pend_q   <= 1'b0;
      lat_q    <= 4'd1;
      vblnk_q  <= 1'b0;
      code_q   <= SPACE_CODE;
      banner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frm_q    <= frm_d;
      pend_q   <= pend_d;
      lat_q    <= lat_d;
      vblnk_q  <= bus.vblnk;
      code_q   <= bus.char_code;
      banner_q <= in_area && vis && (bus.char_code != SPACE_CODE);
    end
  end

  assign bus.level_lat = lat_q;
  assign bus.code_out  = code_q;
  assign bus.banner_on = banner_q;
  assign state_o       = state_q;
  assign frm_cnt_o     = frm_q;
  assign pending_o     = pend_q;

endmodule

// File: tb/tb_text_banner_ctl.sv
// Directed bench for text_banner_ctl: reset, pixel addressing and latency,
// SHOW/BLINK/IDLE sequencing, level restart and async reset abort.
module tb_text_banner_ctl;
  import text_pkg::*;

  localparam logic [10:0] XP = 11'd384;
  localparam logic [10:0] YP = 11'd172;

  logic       pclk;
  logic       rst;
  state_t     state;
  logic [7:0] frm_cnt;
  logic       pending;
  int         n_pass;
  int         n_total;

  text_banner_ctl_if bus ();

  text_banner_ctl dut (
    .pclk      (pclk),
    .rst       (rst),
    .bus       (bus),
    .state_o   (state),
    .frm_cnt_o (frm_cnt),
    .pending_o (pending)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge; vblnk rises for exactly one clock.
  task automatic tick();
    bus.vblnk = 1'b1;
    @(negedge pclk);
    bus.vblnk = 1'b0;
    @(negedge pclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v);
    bus.hcount = h;
    bus.vcount = v;
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    bus.level = 4'd1;
    bus.hcount = 11'd0;
    bus.vcount = 11'd0;
    bus.vblnk = 1'b0;
    bus.char_code = 7'h4C;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge pclk);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_frm", 32'(frm_cnt), 32'd0);
    chk("rst_lat", 32'(bus.level_lat), 32'd1);
    chk("rst_xy", 32'(bus.char_xy), 32'd0);
    chk("rst_line", 32'(bus.char_line), 32'd0);
    chk("rst_banner", 32'(bus.banner_on), 32'd0);
    chk("rst_code", 32'(bus.code_out), 32'h20);
    rst = 1'b0;
    @(negedge pclk);

    // Level 1 -> 3 waits for the frame tick
    bus.level = 4'd3;
    @(negedge pclk);
    chk("pend_wait_state", 32'(state), 32'(IDLE));
    chk("pend_wait_lat", 32'(bus.level_lat), 32'd1);
    chk("pend_set", 32'(pending), 32'd1);
    tick();
    chk("show_lat", 32'(bus.level_lat), 32'd3);
    chk("show_state", 32'(state), 32'(SHOW));
    chk("show_frm", 32'(frm_cnt), 32'd0);

    // Addressing and 2-cycle latency
    bus.hcount = XP + 11'd17;
    bus.vcount = YP + 11'd35;
    @(negedge pclk);
    chk("xy_lat1", 32'(bus.char_xy), 32'h21);
    chk("line_lat1", 32'(bus.char_line), 32'd3);
    chk("banner_not_yet", 32'(bus.banner_on), 32'd0);
    @(negedge pclk);
    chk("banner_lat2", 32'(bus.banner_on), 32'd1);
    chk("code_lat2", 32'(bus.code_out), 32'h4C);

    bus.char_code = 7'h20;
    repeat (2) @(negedge pclk);
    chk("space_off", 32'(bus.banner_on), 32'd0);
    chk("space_code", 32'(bus.code_out), 32'h20);
    bus.char_code = 7'h4C;

    pix(XP - 11'd1, YP + 11'd35);
    chk("left_out", 32'(bus.banner_on), 32'd0);
    pix(XP + 11'd255, YP + 11'd255);
    chk("corner_in", 32'(bus.banner_on), 32'd1);
    chk("corner_xy", 32'(bus.char_xy), 32'hFF);
    pix(XP + 11'd256, YP + 11'd35);
    chk("right_out", 32'(bus.banner_on), 32'd0);
    pix(XP + 11'd17, YP - 11'd1);
    chk("top_out", 32'(bus.banner_on), 32'd0);
    pix(XP + 11'd17, YP + 11'd256);
    chk("bottom_out", 32'(bus.banner_on), 32'd0);
    pix(XP + 11'd17, YP + 11'd35);

    // SHOW end
    ticks(119);
    chk("show_last_state", 32'(state), 32'(SHOW));
    chk("show_last_frm", 32'(frm_cnt), 32'd119);
    chk("show_last_banner", 32'(bus.banner_on), 32'd1);
    tick();
`ifdef TEXT_BANNER_BLINK_EN
    chk("blink_state", 32'(state), 32'(BLINK));
    chk("blink_frm0", 32'(frm_cnt), 32'd0);
    chk("blink_on_0", 32'(bus.banner_on), 32'd1);
    ticks(8);
    chk("blink_frm8", 32'(frm_cnt), 32'd8);
    chk("blink_off_8", 32'(bus.banner_on), 32'd0);
    ticks(7);
    chk("blink_off_15", 32'(bus.banner_on), 32'd0);
    tick();
    chk("blink_on_16", 32'(bus.banner_on), 32'd1);
    ticks(47);
    chk("blink_last_state", 32'(state), 32'(BLINK));
    chk("blink_last_frm", 32'(frm_cnt), 32'd63);
    tick();
`endif
    chk("idle_state", 32'(state), 32'(IDLE));
    chk("idle_banner", 32'(bus.banner_on), 32'd0);
    chk("idle_lat", 32'(bus.level_lat), 32'd3);

    // Change and tick in the same cycle, then restart mid-SHOW
    bus.level = 4'd2;
    tick();
    chk("same_cycle_state", 32'(state), 32'(SHOW));
    chk("same_cycle_lat", 32'(bus.level_lat), 32'd2);
    ticks(50);
    chk("frm50", 32'(frm_cnt), 32'd50);
    bus.level = 4'd5;
    @(negedge pclk);
    chk("mid_frame_lat", 32'(bus.level_lat), 32'd2);
    chk("mid_frame_frm", 32'(frm_cnt), 32'd50);
    tick();
    chk("restart_lat", 32'(bus.level_lat), 32'd5);
    chk("restart_frm", 32'(frm_cnt), 32'd0);
    chk("restart_state", 32'(state), 32'(SHOW));
    bus.level = 4'd0;
    tick();
    chk("lvl0_lat", 32'(bus.level_lat), 32'd5);
    chk("lvl0_frm", 32'(frm_cnt), 32'd1);
    bus.level = 4'd12;
    tick();
    chk("lvl12_lat", 32'(bus.level_lat), 32'd5);
    chk("lvl12_frm", 32'(frm_cnt), 32'd2);
    chk("lvl12_pend", 32'(pending), 32'd0);
    chk("pre_rst_banner", 32'(bus.banner_on), 32'd1);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'(IDLE));
    chk("arst_frm", 32'(frm_cnt), 32'd0);
    chk("arst_banner", 32'(bus.banner_on), 32'd0);
    chk("arst_code", 32'(bus.code_out), 32'h20);
    chk("arst_lat", 32'(bus.level_lat), 32'd1);
    chk("arst_xy", 32'(bus.char_xy), 32'd0);
    chk("arst_line", 32'(bus.char_line), 32'd0);
    bus.level = 4'd1;
    #1 rst = 1'b0;
    @(negedge pclk);
    ticks(3);
    chk("post_rst_state", 32'(state), 32'(IDLE));
    chk("post_rst_banner", 32'(bus.banner_on), 32'd0);
    chk("post_rst_pend", 32'(pending), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/text_banner_ctl.md
TEXT_BANNER_CTL -- requirements
Module: text_banner_ctl

Interface
REQ-001 Parameter XPOS, default 11'd384, left pixel column of the 256x256 text area.
REQ-002 Parameter YPOS, default 11'd172, top pixel row of the text area.
REQ-003 Parameter SHOW_FRAMES, default 8'd120, frames of steady banner display.
REQ-004 Parameter BLINK_FRAMES, default 8'd64, frames of blinking display after SHOW.
REQ-005 pclk  in  1  pixel clock; the block's only clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 level  in  4  current game level, valid values 1..9.
REQ-008 hcount, vcount  in  11 each  current pixel coordinates.
REQ-009 vblnk  in  1  vertical blanking; its rising edge is the frame tick.
REQ-010 char_code  in  7  character code returned by the 16x16 char ROM for char_xy.
REQ-011 char_xy  out  8  ROM address {row[3:0], col[3:0]}.
REQ-012 char_line  out  4  glyph line within the current character, (vcount-YPOS)[3:0].
REQ-013 level_lat  out  4  frame-stable level fed to the char ROM.
REQ-014 banner_on  out  1  pixel lies inside the text area and the banner is currently visible.
REQ-015 code_out  out  7  registered char_code, aligned with banner_on.

Function
REQ-016 Text area: hcount in [XPOS, XPOS+255] and vcount in [YPOS, YPOS+255]; col=(hcount-XPOS)[7:4], row=(vcount-YPOS)[7:4].
REQ-017 char_xy, char_line, and in_area are registered one cycle after hcount/vcount.
REQ-018 code_out and banner_on are registered one cycle after char_xy, giving 2-cycle latency from hcount/vcount.
REQ-019 Frame tick: vblnk high while its registered previous value is low; exactly one cycle per frame.
REQ-020 Level change: level differs from level_lat and lies in 1..9; this sets a pending flag. Values 0 and 10..15 are ignored.
REQ-021 level_lat updates only on a frame tick while pending is set, so there is no mid-frame change.
REQ-022 States: IDLE, SHOW, BLINK; 8-bit frame counter frm_cnt.
REQ-023 IDLE -> SHOW on a tick with pending set; at that transition, frm_cnt=0, pending cleared, and level_lat loaded.
REQ-024 SHOW: frm_cnt increments per tick; at frm_cnt==SHOW_FRAMES-1, go to BLINK and set frm_cnt=0.
REQ-025 BLINK: frm_cnt increments per tick; at frm_cnt==BLINK_FRAMES-1, go to IDLE.
REQ-026 Pending set in SHOW or BLINK restarts SHOW at the next tick with the new level, frm_cnt=0.
REQ-027 A level change and a tick in the same cycle take effect at that tick using the current level input.
REQ-028 Visibility: IDLE gives 0; SHOW gives 1; BLINK gives ~frm_cnt[3], or 1 when blink is compiled out.
REQ-029 banner_on = in_area (delayed) AND visibility AND code_out != 7'h20.

Reset
REQ-030 On rst: state=IDLE, frm_cnt=0, pending=0, level_lat=4'd1, char_xy=0, char_line=0, banner_on=0, code_out=7'h20, vblnk history=0.
REQ-031 rst asserted mid-banner aborts the banner immediately; a level held at 1 after reset triggers nothing.

Configuration
REQ-032 Macro TEXT_BANNER_BLINK_EN defined: BLINK state is present and behaves per REQ-025/028.
REQ-033 Macro TEXT_BANNER_BLINK_EN undefined: SHOW end goes directly to IDLE, BLINK_FRAMES is unused, and no BLINK state is synthesized.

Structure
REQ-034 Shared package/header text_pkg holds the state encodings (IDLE=2'd0, SHOW=2'd1, BLINK=2'd2), TEXT_AREA_W=256, CHAR_PX=16, and SPACE_CODE=7'h20.
REQ-035 One sub-module, text_addr_gen, implements REQ-016/017 (area compare plus col/row/line registers); FSM and output stage stay in the top level.

Verification
REQ-036 Reset, then level 1->3, then 1 frame tick: level_lat=3, state=SHOW; after 120 ticks, BLINK; after 64 more, IDLE.
REQ-037 hcount=XPOS+17, vcount=YPOS+35: char_xy=8'h21 and char_line=3 one cycle later; banner_on follows one cycle after that.
REQ-038 In BLINK, frm_cnt=8..15: banner_on=0 over "L" pixels; frm_cnt=0..7: banner_on=1; with macro undefined, IDLE follows SHOW directly.
REQ-039 Level 2->5 during SHOW frame 50: restart at next tick, level_lat=5, frm_cnt=0; level=0 or 12 causes no change.
REQ-040 rst pulse during SHOW: all outputs take their reset values within the same cycle (async), with no banner until a new level change.
